rom_arbiter_n: RTL and testbench

Parametrised N-channel SDRAM request arbiter and ROM-download writer for arcade cores. It sits between the per-ROM cache segments (each presenting req/addr and taking ack/valid) and the single SDRAM controller port. It generalises the fixed three-ROM priority mux in three ways:
- configurable channel count;
- selectable fixed-priority or round-robin arbitration;
- a tag FIFO that allows several outstanding reads, with each valid routed to the channel that issued the read.

It also packs IOCTL download bytes into 32-bit SDRAM writes.

---
 rtl/rom_arbiter_n.sv | 267 ++++++++++++++++++++++++++
 tb/tb_rom_arbiter_n.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_arbiter_n.sv
// rom_arbiter_n
// Shares one SDRAM controller port between NUM_CH ROM cache channels.
// Arbitration is fixed priority or round-robin. A tag FIFO allows several
// reads to be outstanding, and each returning valid is steered back to the
// channel that issued the read. During an IOCTL download, incoming bytes are
// packed into 32-bit words and written to SDRAM.
module rom_arbiter_n #(
    parameter int NUM_CH     = 4,
    parameter int ADDR_W     = 23,
    parameter int RR         = 1,
    parameter int PEND_DEPTH = 4,
    parameter int DL_INDEX   = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        ch_req,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
    output logic [NUM_CH-1:0]        ch_ack,
    output logic [NUM_CH-1:0]        ch_valid,
    input  logic [24:0]              ioctl_addr,
    input  logic [7:0]               ioctl_data,
    input  logic [15:0]              ioctl_index,
    input  logic                     ioctl_wr,
    input  logic                     ioctl_download,
    output logic [ADDR_W-1:0]        sdram_addr,
    output logic [31:0]              sdram_data,
    output logic                     sdram_we,
    output logic                     sdram_req,
    input  logic                     sdram_ack,
    input  logic                     sdram_valid,
    output logic                     dl_overrun,
    output logic                     spurious_valid
);

    localparam int              GW        = $clog2(NUM_CH);
    localparam int              PW        = $clog2(PEND_DEPTH);
    localparam bit              USE_RR    = (RR != 0);
    localparam logic [GW-1:0]   LAST_CH   = GW'(NUM_CH - 1);
    localparam logic [GW-1:0]   ONE_G     = GW'(1);
    localparam logic [GW:0]     NCH_W     = (GW + 1)'(NUM_CH);
    localparam logic [PW-1:0]   ONE_P     = PW'(1);
    localparam logic [PW:0]     ONE_C     = (PW + 1)'(1);
    localparam logic [PW:0]     CNT_FULL  = (PW + 1)'(PEND_DEPTH);
    localparam logic [15:0]     DL_IDX    = 16'(DL_INDEX);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RD_REQ = 2'd1,
        ST_WR_REQ = 2'd2
    } state_t;

    // One-hot decode of a channel index
    function automatic logic [NUM_CH-1:0] f_onehot(input logic [GW-1:0] idx);
        logic [NUM_CH-1:0] v;
        v      = {NUM_CH{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

    // Registers
    state_t              r_state;
    logic [GW-1:0]       r_grant;
    logic [GW-1:0]       r_ptr;
    logic [ADDR_W-1:0]   r_sdram_addr;
    logic [31:0]         r_sdram_data;
    logic                r_sdram_we;
    logic                r_sdram_req;
    logic [GW-1:0]       r_tag [PEND_DEPTH];
    logic [PW-1:0]       r_wp;
    logic [PW-1:0]       r_rp;
    logic [PW:0]         r_cnt;
    logic                r_spurious;
    logic [23:0]         r_lane_buf;
    logic [31:0]         r_dl_word;
    logic [22:0]         r_dl_addr;
    logic                r_dl_ready;
    logic                r_dl_overrun;

    // Wires
    logic [GW-1:0]       w_base;
    logic [GW:0]         w_sum;
    logic [GW:0]         w_idx;
    logic [GW-1:0]       w_gnt;
    logic                w_found;
    logic [ADDR_W-1:0]   w_rd_addr;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_start_wr;
    logic                w_start_rd;
    logic                w_dl_wr;
    logic                w_word_done;
    logic                w_overrun;

    assign w_base = USE_RR ? r_ptr : {GW{1'b0}};

    // Pick the first requesting channel at or after the base index, wrapping.
    // In fixed-priority mode the base is 0, so the lowest index wins.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = {GW{1'b0}};
        w_sum   = {(GW + 1){1'b0}};
        w_idx   = {(GW + 1){1'b0}};
        for (int k = 0; k < NUM_CH; k++) begin
            w_sum = {1'b0, w_base} + (GW + 1)'(k);
            if (w_sum >= NCH_W) begin
                w_idx = w_sum - NCH_W;
            end else begin
                w_idx = w_sum;
            end
            if (!w_found && ch_req[w_idx[GW-1:0]]) begin
                w_found = 1'b1;
                w_gnt   = w_idx[GW-1:0];
            end else begin
                w_found = w_found;
            end
        end
    end

    assign w_rd_addr   = ch_addr[w_gnt*ADDR_W +: ADDR_W];
    assign w_push      = (r_state == ST_RD_REQ) && sdram_ack;
    assign w_pop       = sdram_valid && (r_cnt != {(PW + 1){1'b0}});
    assign w_full      = (r_cnt == CNT_FULL);
    assign w_start_wr  = (r_state == ST_IDLE) && ioctl_download && r_dl_ready;
    assign w_start_rd  = (r_state == ST_IDLE) && !ioctl_download && w_found && !w_full;
    assign w_dl_wr     = ioctl_download && ioctl_wr;
    assign w_word_done = w_dl_wr && (ioctl_addr[1:0] == 2'd3);
    // A completed word is an overrun if it replaces a word that has not been
    // taken yet, or if it arrives while the previous write is still waiting
    // for its ack.
    assign w_overrun   = w_word_done &&
                         ((r_dl_ready && !w_start_wr) ||
                          ((r_state == ST_WR_REQ) && !sdram_ack));

    // The ack and valid pulses are combinational, so a channel sees them in
    // the same cycle as the SDRAM handshake.
    assign ch_ack   = w_push ? f_onehot(r_grant)    : {NUM_CH{1'b0}};
    assign ch_valid = w_pop  ? f_onehot(r_tag[r_rp]) : {NUM_CH{1'b0}};

    assign sdram_addr     = r_sdram_addr;
    assign sdram_data     = r_sdram_data;
    assign sdram_we       = r_sdram_we;
    assign sdram_req      = r_sdram_req;
    assign dl_overrun     = r_dl_overrun;
    assign spurious_valid = r_spurious;

    // Request FSM: writes take priority over reads; the grant stays locked until ack
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_grant      <= {GW{1'b0}};
            r_ptr        <= {GW{1'b0}};
            r_sdram_addr <= {ADDR_W{1'b0}};
            r_sdram_data <= 32'h0000_0000;
            r_sdram_we   <= 1'b0;
            r_sdram_req  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start_wr) begin
                        r_sdram_addr <= ADDR_W'(r_dl_addr);
                        r_sdram_data <= r_dl_word;
                        r_sdram_we   <= (ioctl_index == DL_IDX);
                        r_sdram_req  <= 1'b1;
                        r_state      <= ST_WR_REQ;
                    end else if (w_start_rd) begin
                        r_grant      <= w_gnt;
                        r_sdram_addr <= w_rd_addr;
                        r_sdram_we   <= 1'b0;
                        r_sdram_req  <= 1'b1;
                        r_state      <= ST_RD_REQ;
                    end else begin
                        r_sdram_req  <= 1'b0;
                    end
                end
                ST_RD_REQ: begin
                    if (sdram_ack) begin
                        r_sdram_req <= 1'b0;
                        r_state     <= ST_IDLE;
                        if (USE_RR) begin
                            r_ptr <= (r_grant == LAST_CH) ? {GW{1'b0}} : r_grant + ONE_G;
                        end
                    end
                end
                ST_WR_REQ: begin
                    if (sdram_ack) begin
                        r_sdram_req <= 1'b0;
                        r_sdram_we  <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_sdram_req <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    // Tag FIFO: push the granted channel on a read ack, pop on each valid
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PEND_DEPTH; i++) begin
                r_tag[i] <= {GW{1'b0}};
            end
            r_wp  <= {PW{1'b0}};
            r_rp  <= {PW{1'b0}};
            r_cnt <= {(PW + 1){1'b0}};
        end else begin
            if (w_push) begin
                r_tag[r_wp] <= r_grant;
                r_wp        <= r_wp + ONE_P;
            end
            if (w_pop) begin
                r_rp <= r_rp + ONE_P;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + ONE_C;
                2'b01:   r_cnt <= r_cnt - ONE_C;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Sticky flag: a valid arrived with no read outstanding
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_spurious <= 1'b0;
        end else if (sdram_valid && (r_cnt == {(PW + 1){1'b0}})) begin
            r_spurious <= 1'b1;
        end
    end

    // Download packer: assemble little-endian bytes and hand completed words to the FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lane_buf   <= 24'h00_0000;
            r_dl_word    <= 32'h0000_0000;
            r_dl_addr    <= 23'h00_0000;
            r_dl_ready   <= 1'b0;
            r_dl_overrun <= 1'b0;
        end else begin
            if (w_dl_wr) begin
                case (ioctl_addr[1:0])
                    2'd0: r_lane_buf[7:0]   <= ioctl_data;
                    2'd1: r_lane_buf[15:8]  <= ioctl_data;
                    2'd2: r_lane_buf[23:16] <= ioctl_data;
                    2'd3: begin
                        r_dl_word <= {ioctl_data, r_lane_buf};
                        r_dl_addr <= ioctl_addr[24:2];
                    end
                    default: r_lane_buf <= r_lane_buf;
                endcase
            end
            // A newly completed word wins over the FSM consuming the old one
            if (w_word_done) begin
                r_dl_ready <= 1'b1;
            end else if (w_start_wr) begin
                r_dl_ready <= 1'b0;
            end
            if (w_overrun) begin
                r_dl_overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rom_arbiter_n.sv
// Directed testbench for rom_arbiter_n. It runs a round-robin instance and a
// fixed-priority instance side by side on identical stimulus.
module tb_rom_arbiter_n;

    localparam int NCH = 4;
    localparam int AW  = 23;

    logic              clk = 1'b0;
    logic              reset;
    logic [NCH-1:0]    ch_req;
    logic [NCH*AW-1:0] ch_addr;
    logic [24:0]       ioctl_addr;
    logic [7:0]        ioctl_data;
    logic [15:0]       ioctl_index;
    logic              ioctl_wr;
    logic              ioctl_download;
    logic              sdram_ack;
    logic              sdram_valid;

    logic [NCH-1:0] rr_ch_ack, rr_ch_valid, fp_ch_ack, fp_ch_valid;
    logic [AW-1:0]  rr_sdram_addr, fp_sdram_addr;
    logic [31:0]    rr_sdram_data, fp_sdram_data;
    logic           rr_sdram_we, rr_sdram_req, rr_dl_overrun, rr_spurious;
    logic           fp_sdram_we, fp_sdram_req, fp_dl_overrun, fp_spurious;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rom_arbiter_n #(.NUM_CH(NCH), .ADDR_W(AW), .RR(1), .PEND_DEPTH(4), .DL_INDEX(0)) u_rr (
        .clk(clk), .reset(reset), .ch_req(ch_req), .ch_addr(ch_addr),
        .ch_ack(rr_ch_ack), .ch_valid(rr_ch_valid),
        .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_index(ioctl_index),
        .ioctl_wr(ioctl_wr), .ioctl_download(ioctl_download),
        .sdram_addr(rr_sdram_addr), .sdram_data(rr_sdram_data), .sdram_we(rr_sdram_we),
        .sdram_req(rr_sdram_req), .sdram_ack(sdram_ack), .sdram_valid(sdram_valid),
        .dl_overrun(rr_dl_overrun), .spurious_valid(rr_spurious)
    );

    rom_arbiter_n #(.NUM_CH(NCH), .ADDR_W(AW), .RR(0), .PEND_DEPTH(4), .DL_INDEX(0)) u_fp (
        .clk(clk), .reset(reset), .ch_req(ch_req), .ch_addr(ch_addr),
        .ch_ack(fp_ch_ack), .ch_valid(fp_ch_valid),
        .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_index(ioctl_index),
        .ioctl_wr(ioctl_wr), .ioctl_download(ioctl_download),
        .sdram_addr(fp_sdram_addr), .sdram_data(fp_sdram_data), .sdram_we(fp_sdram_we),
        .sdram_req(fp_sdram_req), .sdram_ack(sdram_ack), .sdram_valid(sdram_valid),
        .dl_overrun(fp_dl_overrun), .spurious_valid(fp_spurious)
    );

    function automatic logic [31:0] a_of(input int i);
        return 32'h0004_0000 + 32'(i * 17);
    endfunction

    function automatic logic [31:0] oh(input int i);
        return 32'd1 << i;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req();
        int k;
        k = 0;
        while (!rr_sdram_req && k < 30) begin
            cyc();
            k++;
        end
        chk("req_seen", 32'(rr_sdram_req), 32'd1);
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        ch_req         = 4'b0000;
        sdram_ack      = 1'b0;
        sdram_valid    = 1'b0;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_index    = 16'd0;
        cyc();
        cyc();
        reset = 1'b0;
        cyc();
    endtask

    // One read: ack 2 cycles after req, valid a few cycles after ack
    task automatic rd_txn(input int grr, input int gfp);
        wait_req();
        chk("rd_addr_rr", 32'(rr_sdram_addr), a_of(grr));
        chk("rd_we_rr", 32'(rr_sdram_we), 32'd0);
        chk("rd_req_fp", 32'(fp_sdram_req), 32'd1);
        chk("rd_addr_fp", 32'(fp_sdram_addr), a_of(gfp));
        cyc();
        cyc();
        sdram_ack = 1'b1;
        #1;
        chk("ack_rr", 32'(rr_ch_ack), oh(grr));
        chk("ack_fp", 32'(fp_ch_ack), oh(gfp));
        cyc();
        sdram_ack = 1'b0;
        #1;
        chk("ack_end_rr", 32'(rr_ch_ack), 32'd0);
        cyc();
        cyc();
        sdram_valid = 1'b1;
        #1;
        chk("valid_rr", 32'(rr_ch_valid), oh(grr));
        chk("valid_fp", 32'(fp_ch_valid), oh(gfp));
        cyc();
        sdram_valid = 1'b0;
    endtask

    task automatic dl_byte(input logic [24:0] a, input logic [7:0] d);
        ioctl_addr = a;
        ioctl_data = d;
        ioctl_wr   = 1'b1;
        cyc();
        ioctl_wr   = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        ioctl_addr = 25'd0;
        ioctl_data = 8'd0;
        for (int i = 0; i < NCH; i++) begin
            ch_addr[i*AW +: AW] = AW'(a_of(i));
        end
        do_reset();

        // Reset state
        chk("rst_req", 32'(rr_sdram_req), 32'd0);
        chk("rst_addr", 32'(rr_sdram_addr), 32'd0);
        chk("rst_data", rr_sdram_data, 32'd0);
        chk("rst_we", 32'(rr_sdram_we), 32'd0);
        chk("rst_ack", 32'(rr_ch_ack), 32'd0);
        chk("rst_valid", 32'(rr_ch_valid), 32'd0);
        chk("rst_ovr", 32'(rr_dl_overrun), 32'd0);
        chk("rst_spur", 32'(rr_spurious), 32'd0);

        // Plan 1: ch_req=0110 -> fixed priority gives 1,1,1; round-robin 1,2,1
        ch_req = 4'b0110;
        rd_txn(1, 1);
        rd_txn(2, 1);
        rd_txn(1, 1);

        // Plan 2: ch_req=1011 from pointer 0 -> 0,1,3,0,1,3
        do_reset();
        ch_req = 4'b1011;
        rd_txn(0, 0);
        rd_txn(1, 0);
        rd_txn(3, 0);
        rd_txn(0, 0);
        rd_txn(1, 0);
        rd_txn(3, 0);

        // Plan 3: immediate acks, delayed valids -> FIFO fills at 4
        do_reset();
        ch_req = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            wait_req();
            chk("pipe_addr", 32'(rr_sdram_addr), a_of(i));
            sdram_ack = 1'b1;
            #1;
            chk("pipe_ack", 32'(rr_ch_ack), oh(i));
            cyc();
            sdram_ack = 1'b0;
        end
        cyc();
        cyc();
        cyc();
        chk("full_stall", 32'(rr_sdram_req), 32'd0);
        repeat (6) cyc();
        chk("full_stall2", 32'(rr_sdram_req), 32'd0);
        sdram_valid = 1'b1;
        #1;
        chk("pipe_valid0", 32'(rr_ch_valid), oh(0));
        cyc();
        sdram_valid = 1'b0;
        wait_req();
        chk("pipe_regrant", 32'(rr_sdram_addr), a_of(0));
        sdram_ack = 1'b1;
        #1;
        chk("pipe_regrant_ack", 32'(rr_ch_ack), oh(0));
        cyc();
        sdram_ack = 1'b0;
        for (int j = 0; j < 4; j++) begin
            cyc();
            sdram_valid = 1'b1;
            #1;
            chk("pipe_valid", 32'(rr_ch_valid), oh((j + 1) % 4));
            cyc();
            sdram_valid = 1'b0;
        end

        // Plan 4: download packing, index 0 -> we=1
        do_reset();
        ioctl_download = 1'b1;
        ioctl_index    = 16'd0;
        for (int b = 0; b < 4; b++) dl_byte(25'(b), 8'((b + 1) * 17));
        wait_req();
        chk("dl0_addr", 32'(rr_sdram_addr), 32'd0);
        chk("dl0_data", rr_sdram_data, 32'h4433_2211);
        chk("dl0_we", 32'(rr_sdram_we), 32'd1);
        sdram_ack = 1'b1;
        #1;
        chk("dl0_noack", 32'(rr_ch_ack), 32'd0);
        cyc();
        sdram_ack = 1'b0;
        for (int b = 4; b < 8; b++) dl_byte(25'(b), 8'((b + 1) * 17));
        wait_req();
        chk("dl1_addr", 32'(rr_sdram_addr), 32'd1);
        chk("dl1_data", rr_sdram_data, 32'h8877_6655);
        chk("dl1_we", 32'(rr_sdram_we), 32'd1);
        sdram_ack = 1'b1;
        #1;
        cyc();
        sdram_ack = 1'b0;
        ioctl_index = 16'd1;
        for (int b = 0; b < 4; b++) dl_byte(25'(8 + b), 8'((b + 1) * 17));
        wait_req();
        chk("dl2_addr", 32'(rr_sdram_addr), 32'd2);
        chk("dl2_data", rr_sdram_data, 32'h4433_2211);
        chk("dl2_we", 32'(rr_sdram_we), 32'd0);
        sdram_ack = 1'b1;
        #1;
        cyc();
        sdram_ack = 1'b0;
        chk("dl_no_ovr", 32'(rr_dl_overrun), 32'd0);

        // Plan 5: read stalled while two words complete -> overrun, second word only
        do_reset();
        ch_req = 4'b0001;
        wait_req();
        chk("ovr_rd_addr", 32'(rr_sdram_addr), a_of(0));
        ioctl_download = 1'b1;
        ioctl_index    = 16'd0;
        for (int b = 0; b < 4; b++) dl_byte(25'(b), 8'((b + 1) * 17));
        chk("ovr_before", 32'(rr_dl_overrun), 32'd0);
        for (int b = 4; b < 8; b++) dl_byte(25'(b), 8'((b + 1) * 17));
        chk("ovr_set", 32'(rr_dl_overrun), 32'd1);
        chk("ovr_rd_held", 32'(rr_sdram_we), 32'd0);
        sdram_ack = 1'b1;
        #1;
        chk("ovr_rd_ack", 32'(rr_ch_ack), oh(0));
        cyc();
        sdram_ack = 1'b0;
        wait_req();
        chk("ovr_wr_addr", 32'(rr_sdram_addr), 32'd1);
        chk("ovr_wr_data", rr_sdram_data, 32'h8877_6655);
        chk("ovr_wr_we", 32'(rr_sdram_we), 32'd1);
        sdram_ack = 1'b1;
        #1;
        cyc();
        sdram_ack = 1'b0;
        cyc();
        cyc();
        cyc();
        chk("ovr_one_write", 32'(rr_sdram_req), 32'd0);
        sdram_valid = 1'b1;
        #1;
        chk("drain_valid", 32'(rr_ch_valid), oh(0));
        cyc();
        sdram_valid = 1'b0;
        #1;
        chk("spur_before", 32'(rr_spurious), 32'd0);
        sdram_valid = 1'b1;
        #1;
        chk("spur_novalid", 32'(rr_ch_valid), 32'd0);
        cyc();
        sdram_valid = 1'b0;
        chk("spur_set", 32'(rr_spurious), 32'd1);

        // Plan 6: reset during RD_REQ with two tags outstanding
        do_reset();
        ch_req = 4'b0011;
        for (int i = 0; i < 2; i++) begin
            wait_req();
            sdram_ack = 1'b1;
            #1;
            chk("r6_ack", 32'(rr_ch_ack), oh(i));
            cyc();
            sdram_ack = 1'b0;
        end
        wait_req();
        sdram_ack   = 1'b1;
        sdram_valid = 1'b1;
        reset       = 1'b1;
        #1;
        chk("r6_req", 32'(rr_sdram_req), 32'd0);
        chk("r6_addr", 32'(rr_sdram_addr), 32'd0);
        chk("r6_ack0", 32'(rr_ch_ack), 32'd0);
        chk("r6_valid0", 32'(rr_ch_valid), 32'd0);
        cyc();
        sdram_ack   = 1'b0;
        sdram_valid = 1'b0;
        ch_req      = 4'b0000;
        cyc();
        reset = 1'b0;
        cyc();
        chk("r6_spur_clear", 32'(rr_spurious), 32'd0);
        sdram_valid = 1'b1;
        #1;
        chk("r6_no_valid", 32'(rr_ch_valid), 32'd0);
        cyc();
        sdram_valid = 1'b0;
        chk("r6_spur_set", 32'(rr_spurious), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
